ifmap_read_scheduler: RTL and testbench
=======================================

IFMAP_READ_SCHEDULER -- requirements
Module: ifmap_read_scheduler

Interface
REQ-001 The module SHALL have parameter MAX_OUT, default 4, giving the maximum number of outstanding read requests (legal range 1..15).
REQ-002 The module SHALL have parameter FL_CYC, default 2, giving the minimum idle cycles between accepted read requests.
REQ-003 clk  input  1  single clock for the block; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 cfg_valid  input  1  a convolution size is offered.
REQ-006 cfg_ready  output  1  the scheduler accepts the offered size.
REQ-007 cfg_conv_size  input  6  output-map dimension (positions per axis), 0..63.
REQ-008 req_valid  output  1  a read address is presented to ifmap memory.
REQ-009 req_ready  input  1  ifmap memory accepts the address.
REQ-010 req_addr  output  13  {y[12:7], x[6:1], timestep[0]}.
REQ-011 rsp_valid  input  1  ifmap memory returns a window.
REQ-012 rsp_ready  output  1  the scheduler consumes the returned window.
REQ-013 busy  output  1  a job is in progress (state not IDLE).
REQ-014 done  output  1  one-cycle pulse marking job completion.
REQ-015 outstanding  output  4  current count of issued-but-unanswered requests.

Function
REQ-016 State machine SHALL have states IDLE, ISSUE, DRAIN and DONE.
REQ-017 IDLE: cfg_ready=1; on cfg_valid&cfg_ready, latch cfg_conv_size, clear y/x/ts to 0, and go to ISSUE; go to DONE instead if cfg_conv_size==0.
REQ-018 cfg_ready SHALL be 0 in every state except IDLE; cfg_valid outside IDLE SHALL be ignored.
REQ-019 ISSUE: req_valid=1 iff outstanding<MAX_OUT and the FL_CYC gap counter is 0; req_addr SHALL stay stable while req_valid=1 and req_ready=0.
REQ-020 Issue order SHALL be timestep innermost, then x, then y: (y,x,0),(y,x,1),(y,x+1,0) and so on; x wraps to 0 and y increments when x==conv_size-1 and ts==1.
REQ-021 The accept after (conv_size-1, conv_size-1, 1) SHALL move ISSUE to DRAIN; total requests per job = 2*conv_size*conv_size.
REQ-022 Each accepted request SHALL reload the gap counter to FL_CYC; the counter SHALL decrement to 0 once per cycle.
REQ-023 rsp_ready SHALL be 1 whenever outstanding>0 and 0 otherwise.
REQ-024 outstanding SHALL increment on request accept, decrement on rsp_valid&rsp_ready, and stay unchanged when both occur in the same cycle.
REQ-025 DRAIN: go to DONE in the cycle after outstanding reaches 0.
REQ-026 DONE: assert done=1 for exactly one cycle, then return to IDLE.
REQ-027 rsp_valid while outstanding==0 SHALL be ignored and SHALL NOT underflow the count.
REQ-028 Address arithmetic SHALL be 6-bit unsigned; positions SHALL NOT exceed conv_size-1, so no wrap beyond 63 occurs.

Reset
REQ-029 On rst=1, asynchronously: state=IDLE, cfg_ready=1, req_valid=0, req_addr=0, rsp_ready=0, busy=0, done=0, outstanding=0, gap counter=0, latched size=0.
REQ-030 Reset asserted mid-job SHALL abandon the job; responses arriving after reset SHALL be ignored per REQ-027.
REQ-031 The first cfg accept SHALL occur no earlier than the first rising edge after rst deasserts.

Verification
REQ-032 conv_size=2, req_ready=1, rsp returned 1 cycle after each accept -> 8 addresses 0x0000,0x0001,0x0002,0x0003,0x0080,0x0081,0x0082,0x0083, then done pulses once and busy drops.
REQ-033 conv_size=3, MAX_OUT=4, rsp_valid held 0 -> exactly 4 accepts; req_valid stays 0 and outstanding=4 until a response is released.
REQ-034 conv_size=0 -> IDLE to DONE to IDLE with zero requests; done pulses within 2 cycles of the cfg accept.
REQ-035 Accept and response in the same cycle with outstanding=2 -> outstanding stays 2.
REQ-036 rst asserted after the 5th accept with conv_size=4 -> all outputs at reset values immediately; a new cfg with conv_size=1 then yields addresses 0x0000 and 0x0001 only.
REQ-037 req_ready held 0 for 5 cycles in ISSUE -> req_addr unchanged throughout, and no extra request is counted.

Source files
------------

// File: rtl/ifmap_read_scheduler.sv
// Walks a conv_size x conv_size x 2 ifmap window set, issuing reads (ts innermost) with a credit cap and a minimum gap.
// Requests issue same-cycle from registered state; stalls on req_ready=0, the outstanding cap, or the gap counter.
module ifmap_read_scheduler #(
    parameter int MAX_OUT = 4,
    parameter int FL_CYC  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [5:0]  cfg_conv_size,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [12:0] req_addr,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    output logic        busy,
    output logic        done,
    output logic [3:0]  outstanding
);

    localparam int GW = (FL_CYC < 1) ? 1 : $clog2(FL_CYC + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q;
    logic [5:0]      size_q;
    logic [5:0]      y_q;
    logic [5:0]      x_q;
    logic            ts_q;
    logic [GW-1:0]   gap_q;
    logic [3:0]      out_q;

    logic            req_acc;
    logic            rsp_acc;
    logic            last_x;
    logic            last_y;

    assign cfg_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign req_valid   = (state_q == ISSUE) && (out_q < 4'(MAX_OUT)) && (gap_q == '0);
    assign req_addr    = {y_q, x_q, ts_q};
    assign rsp_ready   = (out_q != 4'd0);
    assign outstanding = out_q;

    assign req_acc = req_valid && req_ready;
    // rsp_ready already gates on a non-zero count, so stray responses cannot underflow it
    assign rsp_acc = rsp_valid && rsp_ready;
    assign last_x  = (x_q == size_q - 6'd1);
    assign last_y  = (y_q == size_q - 6'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            size_q  <= 6'd0;
            y_q     <= 6'd0;
            x_q     <= 6'd0;
            ts_q    <= 1'b0;
            gap_q   <= '0;
            out_q   <= 4'd0;
        end else begin
            if (req_acc) begin
                gap_q <= GW'(FL_CYC);
            end else if (gap_q != '0) begin
                gap_q <= gap_q - GW'(1);
            end

            if (req_acc && !rsp_acc) begin
                out_q <= out_q + 4'd1;
            end else if (rsp_acc && !req_acc) begin
                out_q <= out_q - 4'd1;
            end

            case (state_q)
                IDLE: begin
                    if (cfg_valid) begin
                        size_q  <= cfg_conv_size;
                        y_q     <= 6'd0;
                        x_q     <= 6'd0;
                        ts_q    <= 1'b0;
                        state_q <= (cfg_conv_size == 6'd0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (req_acc) begin
                        if (!ts_q) begin
                            ts_q <= 1'b1;
                        end else begin
                            ts_q <= 1'b0;
                            if (!last_x) begin
                                x_q <= x_q + 6'd1;
                            end else begin
                                x_q <= 6'd0;
                                if (!last_y) begin
                                    y_q <= y_q + 6'd1;
                                end else begin
                                    y_q     <= 6'd0;
                                    state_q <= DRAIN;
                                end
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (out_q == 4'd0) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifmap_read_scheduler.sv
// Directed bench for ifmap_read_scheduler with default parameters (MAX_OUT=4, FL_CYC=2).
module tb_ifmap_read_scheduler;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [5:0]  cfg_conv_size;
    logic        req_valid;
    logic        req_ready;
    logic [12:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        busy;
    logic        done;
    logic [3:0]  outstanding;

    int errors = 0;
    int checks = 0;
    logic [12:0] addr_q[$];

    ifmap_read_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_conv_size(cfg_conv_size),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .busy         (busy),
        .done         (done),
        .outstanding  (outstanding)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cfg(input logic [5:0] size);
        cfg_valid     = 1'b1;
        cfg_conv_size = size;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_ready_idle got=%b exp=1", cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
    endtask

    // hold_rsp=1 keeps rsp_valid high; otherwise each accept is answered in the following cycle
    task automatic run_job(input bit hold_rsp, output int n_done, output bit timeout);
        bit pend;
        bit acc;
        pend    = 1'b0;
        timeout = 1'b1;
        n_done  = 0;
        for (int c = 0; c < 2000; c++) begin
            acc = req_valid && req_ready;
            if (acc) addr_q.push_back(req_addr);
            rsp_valid = hold_rsp ? 1'b1 : pend;
            step();
            pend = acc;
            if (done) n_done++;
            if (n_done > 0 && !busy) begin
                timeout = 1'b0;
                break;
            end
        end
        rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (cfg_ready !== 1'b1)      begin errors++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
        checks++; if (req_valid !== 1'b0)      begin errors++; $display("FAIL reset_req_valid got=%b exp=0", req_valid); end
        checks++; if (req_addr !== 13'h0)      begin errors++; $display("FAIL reset_req_addr got=%h exp=0000", req_addr); end
        checks++; if (rsp_ready !== 1'b0)      begin errors++; $display("FAIL reset_rsp_ready got=%b exp=0", rsp_ready); end
        checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)           begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (outstanding !== 4'd0)    begin errors++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic_size2();
        logic [12:0] exp_addr[8];
        int nd;
        bit to;
        exp_addr = '{13'h0000, 13'h0001, 13'h0002, 13'h0003, 13'h0080, 13'h0081, 13'h0082, 13'h0083};
        addr_q.delete();
        req_ready = 1'b1;
        start_cfg(6'd2);
        run_job(1'b0, nd, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout got=%b exp=0", to); end
        checks++; if (addr_q.size() != 8) begin errors++; $display("FAIL basic_count got=%0d exp=8", addr_q.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < addr_q.size()) begin
                checks++;
                if (addr_q[i] !== exp_addr[i]) begin
                    errors++;
                    $display("FAIL basic_addr[%0d] got=%h exp=%h", i, addr_q[i], exp_addr[i]);
                end
            end
        end
        checks++; if (nd != 1)          begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", nd); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
        checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL basic_outstanding_end got=%0d exp=0", outstanding); end
    endtask

    task automatic test_max_out();
        int n;
        int nd;
        bit to;
        addr_q.delete();
        req_ready = 1'b1;
        rsp_valid = 1'b0;
        start_cfg(6'd3);
        n = 0;
        // a competing cfg offered while busy must not be taken
        cfg_valid     = 1'b1;
        cfg_conv_size = 6'd5;
        for (int c = 0; c < 30; c++) begin
            if (req_valid && req_ready) begin
                n++;
                addr_q.push_back(req_addr);
            end
            step();
        end
        checks++; if (cfg_ready !== 1'b0)   begin errors++; $display("FAIL maxout_cfg_ready_busy got=%b exp=0", cfg_ready); end
        cfg_valid = 1'b0;
        checks++; if (n != 4)               begin errors++; $display("FAIL maxout_accepts got=%0d exp=4", n); end
        checks++; if (outstanding !== 4'd4) begin errors++; $display("FAIL maxout_outstanding got=%0d exp=4", outstanding); end
        checks++; if (req_valid !== 1'b0)   begin errors++; $display("FAIL maxout_req_valid got=%b exp=0", req_valid); end
        checks++; if (rsp_ready !== 1'b1)   begin errors++; $display("FAIL maxout_rsp_ready got=%b exp=1", rsp_ready); end
        run_job(1'b1, nd, to);
        checks++; if (to !== 1'b0)          begin errors++; $display("FAIL maxout_timeout got=%b exp=0", to); end
        checks++; if (addr_q.size() != 18)  begin errors++; $display("FAIL maxout_total got=%0d exp=18", addr_q.size()); end
        if (addr_q.size() == 18) begin
            checks++;
            if (addr_q[17] !== 13'h0105) begin errors++; $display("FAIL maxout_last_addr got=%h exp=0105", addr_q[17]); end
        end
        checks++; if (nd != 1)              begin errors++; $display("FAIL maxout_done_pulses got=%0d exp=1", nd); end
    endtask

    task automatic test_zero_size();
        int nd;
        int dcyc;
        int rvs;
        nd   = 0;
        dcyc = -1;
        rvs  = 0;
        req_ready = 1'b1;
        start_cfg(6'd0);
        for (int c = 0; c < 4; c++) begin
            if (req_valid) rvs++;
            if (done) begin
                nd++;
                if (dcyc < 0) dcyc = c;
            end
            step();
        end
        checks++; if (nd != 1)           begin errors++; $display("FAIL zero_done_pulses got=%0d exp=1", nd); end
        checks++; if (dcyc < 0 || dcyc > 1) begin errors++; $display("FAIL zero_done_latency got=%0d exp=0..1", dcyc); end
        checks++; if (rvs != 0)          begin errors++; $display("FAIL zero_req_valid_cycles got=%0d exp=0", rvs); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL zero_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_same_cycle();
        int nd;
        bit to;
        req_ready = 1'b1;
        rsp_valid = 1'b0;
        start_cfg(6'd2);
        for (int c = 0; c < 40; c++) begin
            if (outstanding == 4'd2) break;
            step();
        end
        for (int c = 0; c < 40; c++) begin
            if (req_valid) break;
            step();
        end
        checks++; if (outstanding !== 4'd2) begin errors++; $display("FAIL same_pre_outstanding got=%0d exp=2", outstanding); end
        checks++; if (req_valid !== 1'b1)   begin errors++; $display("FAIL same_req_valid got=%b exp=1", req_valid); end
        rsp_valid = 1'b1;
        step();
        rsp_valid = 1'b0;
        checks++; if (outstanding !== 4'd2) begin errors++; $display("FAIL same_cycle_outstanding got=%0d exp=2", outstanding); end
        run_job(1'b1, nd, to);
        checks++; if (to !== 1'b0 || nd != 1) begin errors++; $display("FAIL same_finish got=to%b/done%0d exp=to0/done1", to, nd); end
    endtask

    task automatic test_backpressure();
        int n;
        int nd;
        bit to;
        logic [12:0] a0;
        addr_q.delete();
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        start_cfg(6'd2);
        n = 0;
        for (int c = 0; c < 60; c++) begin
            if (n == 3) break;
            if (req_valid && req_ready) begin
                n++;
                addr_q.push_back(req_addr);
            end
            step();
        end
        req_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (req_valid) break;
            step();
        end
        a0 = req_addr;
        checks++; if (a0 !== 13'h0003) begin errors++; $display("FAIL bp_addr got=%h exp=0003", a0); end
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (req_addr !== 13'h0003 || req_valid !== 1'b1 || outstanding !== 4'd0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got=addr%h/vld%b/out%0d exp=addr0003/vld1/out0", c, req_addr, req_valid, outstanding);
            end
        end
        req_ready = 1'b1;
        run_job(1'b1, nd, to);
        checks++; if (to !== 1'b0)         begin errors++; $display("FAIL bp_timeout got=%b exp=0", to); end
        checks++; if (addr_q.size() != 8)  begin errors++; $display("FAIL bp_total got=%0d exp=8", addr_q.size()); end
        if (addr_q.size() == 8) begin
            checks++;
            if (addr_q[3] !== 13'h0003 || addr_q[4] !== 13'h0080) begin
                errors++;
                $display("FAIL bp_order got=%h,%h exp=0003,0080", addr_q[3], addr_q[4]);
            end
        end
    endtask

    task automatic test_reset_midjob();
        int n;
        int nd;
        bit to;
        bit pend;
        bit acc;
        req_ready = 1'b1;
        rsp_valid = 1'b0;
        start_cfg(6'd4);
        n    = 0;
        pend = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (n == 5) break;
            acc = req_valid && req_ready;
            if (acc) n++;
            rsp_valid = pend;
            step();
            pend = acc;
        end
        checks++; if (n != 5) begin errors++; $display("FAIL rstmid_accepts got=%0d exp=5", n); end
        rst = 1'b1;
        #1;
        checks++;
        if (cfg_ready !== 1'b1 || req_valid !== 1'b0 || req_addr !== 13'h0 || rsp_ready !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || outstanding !== 4'd0) begin
            errors++;
            $display("FAIL rstmid_outputs got=cr%b rv%b a%h rr%b b%b d%b o%0d exp=cr1 rv0 a0000 rr0 b0 d0 o0",
                     cfg_ready, req_valid, req_addr, rsp_ready, busy, done, outstanding);
        end
        rsp_valid = 1'b1;
        step();
        rst = 1'b0;
        step();
        rsp_valid = 1'b0;
        checks++; if (outstanding !== 4'd0 || rsp_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_stale_rsp got=out%0d/rr%b exp=out0/rr0", outstanding, rsp_ready);
        end
        addr_q.delete();
        start_cfg(6'd1);
        run_job(1'b0, nd, to);
        checks++; if (to !== 1'b0 || nd != 1) begin errors++; $display("FAIL rstmid_job2_end got=to%b/done%0d exp=to0/done1", to, nd); end
        checks++; if (addr_q.size() != 2)     begin errors++; $display("FAIL rstmid_job2_count got=%0d exp=2", addr_q.size()); end
        if (addr_q.size() == 2) begin
            checks++;
            if (addr_q[0] !== 13'h0000 || addr_q[1] !== 13'h0001) begin
                errors++;
                $display("FAIL rstmid_job2_addr got=%h,%h exp=0000,0001", addr_q[0], addr_q[1]);
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        cfg_valid     = 1'b0;
        cfg_conv_size = 6'd0;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        test_reset();
        test_basic_size2();
        test_max_out();
        test_zero_size();
        test_same_cycle();
        test_backpressure();
        test_reset_midjob();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
